// File: rtl/wbq_pkg.sv
// wbq_pkg: shared types and sizing for the write-back queue
package wbq_pkg;
  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_DW = 16;
  localparam int WBQ_AW = 4;
  localparam logic [WBQ_AW-1:0] WBQ_ZERO_REG = '0;
  typedef struct packed {
    logic [WBQ_AW-1:0] rd;
    logic [WBQ_DW-1:0] data;
    logic vld;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_lookup.sv
// wbq_lookup: newest-wins match of one read index against the queued entries
module wbq_lookup
  import wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  wbq_entry_t        ent [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [WBQ_AW-1:0] key,
  output logic              hit,
  output logic [WBQ_DW-1:0] data
);
  // Walk oldest to newest so the last match, closest to tail, sticks.
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[head + PW'(i)].vld && ent[head + PW'(i)].rd == key && key != WBQ_ZERO_REG) begin
        hit = 1'b1;
        data = ent[head + PW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back buffer feeding the RF write port, with read bypass.
// Define WBQ_STATS_EN to add saturating stall_cnt/hold_cnt counters.
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int DW = WBQ_DW,
  parameter int AW = WBQ_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_vld,
  input  logic [AW-1:0]          mem_reg,
  input  logic [DW-1:0]          mem_data,
  output logic                   mem_rdy,
  input  logic                   alu_vld,
  input  logic [AW-1:0]          alu_reg,
  input  logic [DW-1:0]          alu_data,
  output logic                   alu_rdy,
  input  logic                   drain_hold,
  output logic                   rf_write,
  output logic [AW-1:0]          rf_dst,
  output logic [DW-1:0]          rf_data,
  input  logic [AW-1:0]          rd_reg1,
  input  logic [AW-1:0]          rd_reg2,
  output logic                   byp_hit1,
  output logic [DW-1:0]          byp_data1,
  output logic                   byp_hit2,
  output logic [DW-1:0]          byp_data2,
  output logic [$clog2(DEPTH):0] count
`ifdef WBQ_STATS_EN
  ,
  output logic [15:0]            stall_cnt,
  output logic [15:0]            hold_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wbq_entry_t ent [DEPTH];
  logic [PW-1:0] head, tail, aluIdx;
  logic [CW-1:0] freeSlots;
  logic notEmpty, memEnq, aluEnq;
  assign notEmpty = count != '0;
  assign rf_write = notEmpty & ~drain_hold;
  assign rf_dst = notEmpty ? ent[head].rd : '0;
  assign rf_data = notEmpty ? ent[head].data : '0;
  // A same-cycle pop frees its slot before the accept decision.
  assign freeSlots = CW'(DEPTH) - count + CW'(rf_write);
  assign mem_rdy = freeSlots >= CW'(1);
  assign alu_rdy = freeSlots >= (mem_vld ? CW'(2) : CW'(1));
  assign memEnq = mem_vld & mem_rdy & (mem_reg != WBQ_ZERO_REG);
  assign aluEnq = alu_vld & alu_rdy & (alu_reg != WBQ_ZERO_REG);
  assign aluIdx = tail + PW'(memEnq);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (rf_write) begin
        ent[head].vld <= 1'b0;
        head <= head + PW'(1);
      end
      if (memEnq) ent[tail] <= '{rd: mem_reg, data: mem_data, vld: 1'b1};
      if (aluEnq) ent[aluIdx] <= '{rd: alu_reg, data: alu_data, vld: 1'b1};
      tail <= tail + PW'(memEnq) + PW'(aluEnq);
      count <= count + CW'(memEnq) + CW'(aluEnq) - CW'(rf_write);
    end
  end
  wbq_lookup #(.DEPTH(DEPTH)) uLook1 (
    .ent(ent), .head(head), .key(rd_reg1), .hit(byp_hit1), .data(byp_data1)
  );
  wbq_lookup #(.DEPTH(DEPTH)) uLook2 (
    .ent(ent), .head(head), .key(rd_reg2), .hit(byp_hit2), .data(byp_data2)
  );
`ifdef WBQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (((mem_vld & ~mem_rdy) | (alu_vld & ~alu_rdy)) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (drain_hold && notEmpty && hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: queue-model scoreboard plus directed literal checks for wb_write_queue
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_vld = 1'b0, alu_vld = 1'b0, drain_hold = 1'b0;
  logic [3:0] mem_reg = '0, alu_reg = '0, rd_reg1 = '0, rd_reg2 = '0;
  logic [15:0] mem_data = '0, alu_data = '0;
  logic mem_rdy, alu_rdy, rf_write, byp_hit1, byp_hit2;
  logic [3:0] rf_dst;
  logic [15:0] rf_data, byp_data1, byp_data2;
  logic [2:0] count;
`ifdef WBQ_STATS_EN
  logic [15:0] stall_cnt, hold_cnt;
`endif
  typedef struct {logic [3:0] r; logic [15:0] d;} ent_t;
  ent_t q[$];
  int nChecks = 0;
  int nFail = 0;

  wb_write_queue dut (
    .clk(clk), .rst(rst),
    .mem_vld(mem_vld), .mem_reg(mem_reg), .mem_data(mem_data), .mem_rdy(mem_rdy),
    .alu_vld(alu_vld), .alu_reg(alu_reg), .alu_data(alu_data), .alu_rdy(alu_rdy),
    .drain_hold(drain_hold), .rf_write(rf_write), .rf_dst(rf_dst), .rf_data(rf_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count)
`ifdef WBQ_STATS_EN
    , .stall_cnt(stall_cnt), .hold_cnt(hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nChecks++;
    if (a !== e) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic void look(input logic [3:0] k, output bit h, output logic [15:0] d);
    h = 1'b0;
    d = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (k != 0 && q[i].r == k) begin
        h = 1'b1;
        d = q[i].d;
        break;
      end
  endfunction

  // One cycle: compare every output against the queue model at negedge, advance the model at posedge.
  task automatic tick();
    int n, fr;
    bit pop, mr, ar, h1, h2, memAcc, aluAcc;
    logic [3:0] eDst;
    logic [15:0] eDat, d1, d2;
    @(negedge clk);
    #1;
    if (rst) q.delete();
    n = q.size();
    pop = (n != 0) && !drain_hold;
    fr = 4 - n + int'(pop);
    mr = fr >= 1;
    ar = fr >= (mem_vld ? 2 : 1);
    eDst = '0;
    eDat = '0;
    if (n != 0) begin
      eDst = q[0].r;
      eDat = q[0].d;
    end
    look(rd_reg1, h1, d1);
    look(rd_reg2, h2, d2);
    chk("count", 32'(count), 32'(n));
    chk("rf_write", 32'(rf_write), 32'(pop));
    chk("rf_dst", 32'(rf_dst), 32'(eDst));
    chk("rf_data", 32'(rf_data), 32'(eDat));
    chk("mem_rdy", 32'(mem_rdy), 32'(mr));
    chk("alu_rdy", 32'(alu_rdy), 32'(ar));
    chk("byp_hit1", 32'(byp_hit1), 32'(h1));
    chk("byp_data1", 32'(byp_data1), 32'(d1));
    chk("byp_hit2", 32'(byp_hit2), 32'(h2));
    chk("byp_data2", 32'(byp_data2), 32'(d2));
    memAcc = mem_vld && mr && mem_reg != 0;
    aluAcc = alu_vld && ar && alu_reg != 0;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (memAcc) q.push_back('{mem_reg, mem_data});
      if (aluAcc) q.push_back('{alu_reg, alu_data});
    end
    #1;
  endtask

  initial begin
    // Reset held with both producers requesting
    mem_vld = 1'b1; mem_reg = 4'd1; mem_data = 16'h1111;
    alu_vld = 1'b1; alu_reg = 4'd2; alu_data = 16'h2222;
    rd_reg1 = 4'd1; rd_reg2 = 4'd2;
    tick();
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_hit1", 32'(byp_hit1), 32'd0);
    chk("rst_hit2", 32'(byp_hit2), 32'd0);
    rst = 1'b0;
    tick();
    mem_vld = 1'b0; alu_vld = 1'b0;
    #1;
    chk("first_accept_count", 32'(count), 32'd2);
    tick();
    tick();
    // Single ALU write R3
    alu_vld = 1'b1; alu_reg = 4'd3; alu_data = 16'h1234; rd_reg1 = 4'd3;
    tick();
    alu_vld = 1'b0;
    #1;
    chk("t2_rf_write", 32'(rf_write), 32'd1);
    chk("t2_rf_dst", 32'(rf_dst), 32'd3);
    chk("t2_rf_data", 32'(rf_data), 32'h1234);
    chk("t2_hit1", 32'(byp_hit1), 32'd1);
    tick();
    chk("t2_count_after", 32'(count), 32'd0);
    // Dual accept to the same register under hold
    drain_hold = 1'b1; rd_reg1 = 4'd5;
    mem_vld = 1'b1; mem_reg = 4'd5; mem_data = 16'hAAAA;
    alu_vld = 1'b1; alu_reg = 4'd5; alu_data = 16'hBBBB;
    tick();
    mem_vld = 1'b0; alu_vld = 1'b0;
    #1;
    chk("t3_count", 32'(count), 32'd2);
    chk("t3_byp_newest", 32'(byp_data1), 32'hBBBB);
    drain_hold = 1'b0;
    #1;
    chk("t3_drain_first", 32'(rf_data), 32'hAAAA);
    tick();
    chk("t3_drain_second", 32'(rf_data), 32'hBBBB);
    chk("t3_byp_head", 32'(byp_data1), 32'hBBBB);
    tick();
    // Fill to full under hold, then pop+enqueue together
    drain_hold = 1'b1; rd_reg2 = 4'd9;
    mem_vld = 1'b1; mem_reg = 4'd6; mem_data = 16'h0606;
    alu_vld = 1'b1; alu_reg = 4'd7; alu_data = 16'h0707;
    tick();
    mem_reg = 4'd8; mem_data = 16'h0808; alu_reg = 4'd9; alu_data = 16'h0909;
    tick();
    mem_reg = 4'd10; mem_data = 16'hA0A0; alu_reg = 4'd11; alu_data = 16'hB0B0;
    #1;
    chk("t4_full_count", 32'(count), 32'd4);
    chk("t4_full_mem_rdy", 32'(mem_rdy), 32'd0);
    chk("t4_full_alu_rdy", 32'(alu_rdy), 32'd0);
    chk("t4_byp_r9", 32'(byp_data2), 32'h0909);
    tick();
    drain_hold = 1'b0;
    #1;
    chk("t4_pop_mem_rdy", 32'(mem_rdy), 32'd1);
    chk("t4_pop_alu_rdy", 32'(alu_rdy), 32'd0);
    tick();
    mem_vld = 1'b0; drain_hold = 1'b1;
    #1;
    chk("t4_count_stays", 32'(count), 32'd4);
    chk("t4_rf_dst_r7", 32'(rf_dst), 32'd7);
    drain_hold = 1'b0;
    tick();
    alu_vld = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    // Register 0 writes are swallowed
    rd_reg1 = 4'd0; rd_reg2 = 4'd0;
    alu_vld = 1'b1; alu_reg = 4'd0; alu_data = 16'hFFFF;
    #1;
    chk("t5_alu_rdy", 32'(alu_rdy), 32'd1);
    tick();
    alu_vld = 1'b0;
    #1;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_rf_write", 32'(rf_write), 32'd0);
    chk("t5_hit1", 32'(byp_hit1), 32'd0);
    // Asynchronous reset with three entries pending
    drain_hold = 1'b1;
    mem_vld = 1'b1; mem_reg = 4'd1; mem_data = 16'h0101;
    alu_vld = 1'b1; alu_reg = 4'd2; alu_data = 16'h0202;
    tick();
    alu_vld = 1'b0; mem_reg = 4'd3; mem_data = 16'h0303;
    tick();
    mem_vld = 1'b0; drain_hold = 1'b0;
    #1;
    chk("t6_count3", 32'(count), 32'd3);
    chk("t6_pre_write", 32'(rf_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_write", 32'(rf_write), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_no_stale", 32'(rf_write), 32'd0);
    tick();
    tick();
    // Mixed traffic scored only by the model
    for (int i = 0; i < 24; i++) begin
      mem_vld = (i % 3) != 2; mem_reg = 4'(i); mem_data = 16'(i * 16'h0111);
      alu_vld = (i % 2) == 1; alu_reg = 4'(i + 5); alu_data = 16'(16'hC000 + i);
      drain_hold = (i % 5) == 1;
      rd_reg1 = 4'(i); rd_reg2 = 4'(i + 5);
      tick();
    end
    mem_vld = 1'b0; alu_vld = 1'b0; drain_hold = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
